// File: rtl/cci_mpf_prim_rob_mc.sv
// Multi-channel reorder buffer: entries are allocated in order per channel,
// their payloads may arrive in any order, and each channel is dequeued
// strictly in allocation order. Ready channels are served round-robin.
// Dequeued data appears on the T2_* outputs two cycles after deq_en.
module cci_mpf_prim_rob_mc #(
    parameter int N_CHANNELS     = 4,
    parameter int N_ENTRIES      = 32,
    parameter int N_DATA_BITS    = 64,
    parameter int N_META_BITS    = 1,
    parameter int MIN_FREE_SLOTS = 1,
    localparam int CW = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1,
    localparam int IW = $clog2(N_ENTRIES),
    localparam int MW = (N_META_BITS > 0) ? N_META_BITS : 1
) (
    input  logic                   clk,
    input  logic                   reset,

    input  logic                   alloc_en,
    input  logic [CW-1:0]          allocChan,
    input  logic [MW-1:0]          allocMeta,
    output logic [N_CHANNELS-1:0]  notFull,
    output logic [CW+IW-1:0]       allocIdx,

    input  logic                   enqData_en,
    input  logic [CW+IW-1:0]       enqDataIdx,
    input  logic [N_DATA_BITS-1:0] enqData,

    input  logic                   deq_en,
    output logic                   notEmpty,
    output logic [CW-1:0]          firstChan,

    output logic                   T2_valid,
    output logic [N_DATA_BITS-1:0] T2_first,
    output logic [MW-1:0]          T2_firstMeta,
    output logic [CW-1:0]          T2_firstChan
);

    // Global index space is {chan, local}; sized to 2**(CW+IW) so any
    // index value addresses a real storage row.
    localparam int NG = 1 << (CW + IW);

    logic [IW-1:0]          newest [N_CHANNELS];
    logic [IW-1:0]          oldest [N_CHANNELS];
    logic [IW:0]            count  [N_CHANNELS];
    logic [NG-1:0]          valid;
    logic [CW-1:0]          rr_ptr;
    logic [N_CHANNELS-1:0]  ready;

    logic [N_DATA_BITS-1:0] data_mem [NG];
    logic [MW-1:0]          meta_mem [NG];

    logic                   t1_valid;
    logic [CW+IW-1:0]       t1_idx;
    logic [CW-1:0]          t1_chan;
    logic [CW+IW-1:0]       deq_idx;

    assign allocIdx = {allocChan, newest[allocChan]};
    assign notEmpty = |ready;
    assign deq_idx  = {firstChan, oldest[firstChan]};

    // Per-channel readiness and space, from registered state only.
    always_comb begin
        for (int c = 0; c < N_CHANNELS; c++) begin
            ready[c]   = (count[c] != '0) && valid[{CW'(c), oldest[c]}];
            notFull[c] = (N_ENTRIES - int'(count[c])) > MIN_FREE_SLOTS;
        end
    end

    // Round-robin pick: nearest ready channel at or after rr_ptr wins.
    always_comb begin
        firstChan = rr_ptr;
        for (int i = N_CHANNELS - 1; i >= 0; i--) begin
            if (ready[CW'((int'(rr_ptr) + i) % N_CHANNELS)])
                firstChan = CW'((int'(rr_ptr) + i) % N_CHANNELS);
        end
    end

    // Ring pointers, occupancy, valid bits, arbiter pointer and read pipe valids.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < N_CHANNELS; c++) begin
                newest[c] <= '0;
                oldest[c] <= '0;
                count[c]  <= '0;
            end
            valid    <= '0;
            rr_ptr   <= '0;
            t1_valid <= 1'b0;
            T2_valid <= 1'b0;
        end else begin
            for (int c = 0; c < N_CHANNELS; c++) begin
                if (alloc_en && (allocChan == CW'(c)))
                    newest[c] <= newest[c] + IW'(1);
                if (deq_en && (firstChan == CW'(c)))
                    oldest[c] <= oldest[c] + IW'(1);
                if ((alloc_en && (allocChan == CW'(c))) && !(deq_en && (firstChan == CW'(c))))
                    count[c] <= count[c] + (IW+1)'(1);
                else if (!(alloc_en && (allocChan == CW'(c))) && (deq_en && (firstChan == CW'(c))))
                    count[c] <= count[c] - (IW+1)'(1);
            end
            if (enqData_en)
                valid[enqDataIdx] <= 1'b1;
            if (deq_en) begin
                valid[deq_idx] <= 1'b0;
                rr_ptr         <= CW'((int'(firstChan) + 1) % N_CHANNELS);
            end
            t1_valid <= deq_en;
            T2_valid <= t1_valid;
        end
    end

    // Storage writes and the two-stage read path; contents need no reset.
    // A slot freed by a dequeue may be re-allocated while its read is in
    // flight; the read samples the old meta on the same edge, so no hazard.
    always_ff @(posedge clk) begin
        if (alloc_en && !reset)
            meta_mem[allocIdx] <= allocMeta;
        if (enqData_en && !reset)
            data_mem[enqDataIdx] <= enqData;
        t1_idx       <= deq_idx;
        t1_chan      <= firstChan;
        T2_first     <= data_mem[t1_idx];
        T2_firstMeta <= meta_mem[t1_idx];
        T2_firstChan <= t1_chan;
    end

`ifndef SYNTHESIS
    logic [CW-1:0] enq_chan;
    logic [IW-1:0] enq_off;
    logic          enq_allocated;

    assign enq_chan      = enqDataIdx[CW+IW-1:IW];
    assign enq_off       = enqDataIdx[IW-1:0] - oldest[enq_chan];
    assign enq_allocated = {1'b0, enq_off} < count[enq_chan];

    // Protocol and configuration checks.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert ((N_CHANNELS & (N_CHANNELS - 1)) == 0)
                else $fatal(1, "N_CHANNELS must be a power of 2");
            assert ((N_ENTRIES & (N_ENTRIES - 1)) == 0)
                else $fatal(1, "N_ENTRIES must be a power of 2");
            if (alloc_en)
                assert (count[allocChan] != (IW+1)'(N_ENTRIES))
                    else $fatal(1, "alloc into full channel %0d", allocChan);
            if (deq_en)
                assert (notEmpty)
                    else $fatal(1, "deq_en with nothing ready");
            if (enqData_en)
                assert (enq_allocated && !valid[enqDataIdx])
                    else $fatal(1, "enqData to unallocated or valid entry %0d", enqDataIdx);
        end
    end
`endif

endmodule
